// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: hazard inputs and stall/flush controls between the pipeline and the hazard sequencer
interface pipeline_hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        md_start;
  logic        branch_taken;
  logic        dmem_wait;
  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        memwb_en;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        memwb_flush;
  logic        md_busy;
  logic [15:0] stall_cycles;
  modport master (
    output id_rs, id_rt, ex_mem_read, ex_rt, md_start, branch_taken, dmem_wait,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, exmem_flush, memwb_flush, md_busy, stall_cycles
  );
  modport slave (
    input  id_rs, id_rt, ex_mem_read, ex_rt, md_start, branch_taken, dmem_wait,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, exmem_flush, memwb_flush, md_busy, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: prioritised stall/flush sequencer for the 5-stage pipeline; STALL_CNT_EN adds a stall cycle counter
module pipeline_hazard_ctrl #(
  parameter int MD_CYCLES = 4,
  parameter int CNT_W     = 3
) (
  input  logic clk,
  input  logic reset,
  pipeline_hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {RUN, MD_BUSY, MD_DONE} state_t;
  localparam logic [9:0] CTL_IDLE = 10'b11111_0000_0;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             md_stall, load_use;
  logic [9:0]       ctl;
  assign md_stall = state_q == MD_BUSY || (state_q == RUN && hz.md_start);
  assign load_use = hz.ex_mem_read && hz.ex_rt != 5'd0 &&
                    (hz.ex_rt == hz.id_rs || hz.ex_rt == hz.id_rt);
  // Control word {pc,ifid,idex,exmem,memwb en | ifid,idex,exmem,memwb flush | md_busy}, highest-priority hazard wins
  always_comb
    ctl = !reset       ? CTL_IDLE :
          hz.dmem_wait ? 10'b00001_0001_0 :
          md_stall     ? 10'b00011_0010_1 :
          load_use     ? 10'b00111_0100_0 :
          hz.branch_taken ? 10'b11111_1000_0 : CTL_IDLE;
  assign {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en} = ctl[9:5];
  assign {hz.ifid_flush, hz.idex_flush, hz.exmem_flush, hz.memwb_flush} = ctl[4:1];
  assign hz.md_busy = ctl[0];
  // Mult/div sequencing: the counter runs on even while memory freezes the pipe; MD_DONE waits for the pipe to move
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == RUN && hz.md_start && !hz.dmem_wait) begin
      state_d = MD_BUSY;
      cnt_d   = CNT_W'(MD_CYCLES - 2);
    end else if (state_q == MD_BUSY) begin
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      else state_d = MD_DONE;
    end else if (state_q == MD_DONE && !hz.dmem_wait) begin
      state_d = RUN;
    end
  end
  // State register, updated on the same falling edge as the pipeline registers
  always_ff @(negedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`ifdef STALL_CNT_EN
  logic [15:0] stall_q, stall_d;
  assign stall_d = (!hz.pc_en && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  assign hz.stall_cycles = stall_q;
  // Saturating count of cycles in which the PC was held
  always_ff @(negedge clk) begin
    if (!reset) stall_q <= '0;
    else stall_q <= stall_d;
  end
`else
  assign hz.stall_cycles = 16'h0000;
`endif
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. It drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC write enable. It resolves four hazard sources by fixed priority: data-memory wait, multi-cycle mult/div, load-use and taken branch. It holds the multi-cycle mult/div sequencing state so each mult/div instruction stalls the front end exactly once.

## Interface
- MD_CYCLES, 4: total stall cycles for one mult/div (legal 2..2^CNT_W)
- CNT_W, 3: width of mult/div down-counter
- clk  in  1  clock; all state updates on falling edge (same edge as pipeline registers)
- reset  in  1  reset, synchronous, active-low
- id_rs, id_rt  in  5 each  source registers of instruction in ID
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  5  load destination register in EX
- md_start  in  1  instruction in EX is mult/div
- branch_taken  in  1  branch in ID resolved taken
- dmem_wait  in  1  data memory not ready this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  register flushes (bubble)
- md_busy  out  1  mult/div stall in progress
- stall_cycles  out  16  stall cycle counter (see Configuration)

## Operation
- States: RUN, MD_BUSY, MD_DONE; down-counter cnt[CNT_W-1:0].
- Outputs are combinational from state and current inputs. Defaults: all *_en=1, all *_flush=0, md_busy=0. The first matching rule applies:
  1. dmem_wait=1: pc/ifid/idex/exmem en=0, memwb_flush=1. Any other stall is also frozen.
  2. md stall: state MD_BUSY, or (RUN and md_start=1). pc/ifid/idex en=0, exmem_flush=1, memwb_en=1, md_busy=1.
  3. load-use: ex_mem_read=1, ex_rt!=0, and ex_rt==id_rs or ex_rt==id_rt. pc_en=ifid_en=0, idex_flush=1.
  4. branch_taken=1: ifid_flush=1. pc_en stays 1 so the target is fetched.
- A branch under a higher-priority stall is ignored. Its ID instruction is held, so it is re-evaluated on the next unstalled cycle.
- Transitions, evaluated on the falling edge:
  - RUN, md_start=1, dmem_wait=0: go to MD_BUSY, cnt<=MD_CYCLES-2.
  - RUN, md_start=1, dmem_wait=1: stay in RUN; the start is re-seen next cycle.
  - MD_BUSY, cnt!=0: cnt<=cnt-1. cnt decrements regardless of dmem_wait.
  - MD_BUSY, cnt==0: go to MD_DONE.
  - MD_DONE: md_start is ignored and the rule 2 md stall is inactive. Leave to RUN on the first cycle with dmem_wait=0, which is the cycle ID/EX advances.
- Never assert a flush and an enable=0 on the same register.

## Timing
- Reset, reset=0 sampled at the falling edge: state=RUN, cnt=0, stall_cycles=0. While reset=0, outputs are forced to all en=1, all flush=0, md_busy=0.
- Load-use: exactly 1 bubble cycle.
- Taken branch: 1 flushed slot, no PC stall.
- Mult/div with dmem_wait=0: exactly MD_CYCLES stall cycles, counting the cycle md_start is first seen.
  - This is followed by 1 MD_DONE cycle in which the pipeline advances normally. Load-use and branch rules still apply in that cycle.
- dmem_wait in MD_BUSY: the stall extends beyond MD_CYCLES only if dmem_wait is still high after cnt expires. The block then remains in MD_DONE, frozen.
- Reset mid-MD_BUSY: returns to RUN next edge with no residual stall.

## Configuration
- STALL_CNT_EN defined: stall_cycles increments on every falling edge where reset=1 and pc_en=0. It saturates at 16'hFFFF and clears on reset.
- STALL_CNT_EN undefined: no counter logic; stall_cycles is tied to 16'h0000.

## Test plan
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1 for 1 cycle. Repeat with ex_rt=0 -> no stall.
- Branch: branch_taken=1, no other hazard -> ifid_flush=1, pc_en=1 for 1 cycle. Branch with a concurrent load-use -> load-use stall only, ifid_flush=0.
- Mult/div, MD_CYCLES=4: md_start held high until idex_en=1 -> md_busy=1 and exmem_flush=1 for exactly 4 cycles. Next cycle md_busy=0 and idex_en=1, with no retrigger.
- dmem_wait: assert for 3 cycles in RUN -> pc/ifid/idex/exmem en=0 and memwb_flush=1 for 3 cycles. Assert across the end of MD_BUSY -> block stays in MD_DONE frozen; RUN is resumed the cycle after dmem_wait falls.
- Reset: drive reset=0 during MD_BUSY with cnt=2 -> next edge md_busy=0, all en=1, and stall_cycles=0 under STALL_CNT_EN.
- STALL_CNT_EN: 1 load-use + 4-cycle mult/div + 3 dmem_wait cycles -> stall_cycles=8. Without the macro -> 0.
